// File: rtl/conv_pkg.sv
// Shared convolution pipeline types.
// Pixel, kernel position flags and egress FIFO entry layout.
package conv_pkg;

  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef struct packed {
    logic n2;
    logic n1;
    logic s1;
    logic s2;
    logic w2;
    logic w1;
    logic e1;
    logic e2;
  } kernel_pos_t;

  localparam int KERNEL_POS_W = $bits(kernel_pos_t);

  typedef struct packed {
    pixel_t pix;
    logic   sof;
    logic   eol;
  } egress_entry_t;

  localparam int EGRESS_ERR_W = 3;
  localparam int ERR_OVF = 0;
  localparam int ERR_SOF = 1;
  localparam int ERR_EOL = 2;

endpackage

// File: rtl/conv_egress_fifo.sv
// Synchronous FIFO with extended pointers for full/empty.
// Push into full and pop from empty are ignored.
module conv_egress_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv_egress.sv
// Convolution egress: elastic FIFO, registered AXIS master,
// early-stall credit and frame geometry checking.
module conv_egress
  import conv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LAT   = 2,
  parameter int DIM_W = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    in_vld_i,
  input  logic [PIXEL_W-1:0]      in_dat_i,
  input  logic [KERNEL_POS_W-1:0] in_pos_i,
  output logic                    in_rdy_o,
  output logic                    m_tvalid_o,
  output logic [PIXEL_W-1:0]      m_tdata_o,
  output logic                    m_tuser_o,
  output logic                    m_tlast_o,
  input  logic                    m_tready_i,
  input  logic [DIM_W-1:0]        cfg_width_i,
  input  logic [DIM_W-1:0]        cfg_height_i,
  output logic                    frame_done_o,
  output logic [EGRESS_ERR_W-1:0] err_o,
  input  logic                    err_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 2;

  kernel_pos_t       pos;
  egress_entry_t     in_entry;
  egress_entry_t     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_cnt;
  logic [OW-1:0]     occ;
  logic [OW-1:0]     occ_next;
  logic              deq;
  logic              load;
  logic              full_all;
  logic              accept;
  logic              ovf;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;

  assign pos          = kernel_pos_t'(in_pos_i);
  assign in_entry.pix = in_dat_i;
  assign in_entry.sof = pos.n2 & pos.w2;
  assign in_entry.eol = pos.e2;

  // The output register is part of the buffering budget.
  assign occ       = OW'(fifo_cnt) + OW'(m_tvalid_o);
  assign deq       = m_tvalid_o & m_tready_i;
  assign load      = ~m_tvalid_o | m_tready_i;
  assign full_all  = (occ == OW'(DEPTH));
  assign accept    = in_vld_i & (~full_all | deq);
  assign ovf       = in_vld_i & ~accept;
  assign bypass    = load & fifo_empty & accept;
  assign fifo_push = accept & ~bypass;
  assign fifo_pop  = load & ~fifo_empty;
  assign occ_next  = occ + OW'(accept) - OW'(deq);

  conv_egress_fifo #(
    .W     ($bits(egress_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .arst  (arst),
    .push  (fifo_push),
    .wdata (in_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= '0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
    end else if (load) begin
      if (!fifo_empty) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= head.pix;
        m_tuser_o  <= head.sof;
        m_tlast_o  <= head.eol;
      end else if (accept) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= in_entry.pix;
        m_tuser_o  <= in_entry.sof;
        m_tlast_o  <= in_entry.eol;
      end else begin
        m_tvalid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) in_rdy_o <= 1'b1;
    else      in_rdy_o <= (occ_next <= OW'(DEPTH - LAT - 1));
  end

  logic [DIM_W-1:0]        col;
  logic [DIM_W-1:0]        row;
  logic [DIM_W-1:0]        bcol;
  logic [DIM_W-1:0]        brow;
  logic                    exp_sof;
  logic                    exp_eol;
  logic                    at_eol;
  logic                    last_row;
  logic [EGRESS_ERR_W-1:0] ev;

  // A SOF beat restarts the count at the frame origin.
  assign bcol     = in_entry.sof ? '0 : col;
  assign brow     = in_entry.sof ? '0 : row;
  assign exp_sof  = (col == '0) && (row == '0);
  assign exp_eol  = (col == cfg_width_i - DIM_W'(1));
  assign at_eol   = (bcol == cfg_width_i - DIM_W'(1));
  assign last_row = (brow == cfg_height_i - DIM_W'(1));

  always_comb begin
    ev          = '0;
    ev[ERR_OVF] = ovf;
    ev[ERR_SOF] = accept & (in_entry.sof != exp_sof);
    ev[ERR_EOL] = accept & (in_entry.eol != exp_eol);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      col          <= '0;
      row          <= '0;
      frame_done_o <= 1'b0;
      err_o        <= '0;
    end else begin
      frame_done_o <= accept & at_eol & last_row;
      err_o        <= (err_o & ~{EGRESS_ERR_W{err_clr_i}}) | ev;
      if (accept) begin
        if (at_eol) begin
          col <= '0;
          row <= last_row ? '0 : brow + DIM_W'(1);
        end else begin
          col <= bcol + DIM_W'(1);
          row <= brow;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_egress.sv
// Scoreboard bench for conv_egress: framing, back-pressure,
// overflow, geometry errors and asynchronous reset.
module tb_conv_egress;
  import conv_pkg::*;

  logic                    clk = 1'b0;
  logic                    arst;
  logic                    in_vld;
  logic [PIXEL_W-1:0]      in_dat;
  kernel_pos_t             in_pos;
  logic                    in_rdy;
  logic                    m_tvalid;
  logic [PIXEL_W-1:0]      m_tdata;
  logic                    m_tuser;
  logic                    m_tlast;
  logic                    m_tready;
  logic [15:0]             cfg_w;
  logic [15:0]             cfg_h;
  logic                    frame_done;
  logic [EGRESS_ERR_W-1:0] err;
  logic                    err_clr;

  int n_checks = 0;
  int n_errors = 0;

  egress_entry_t q[$];
  logic          stall_q = 1'b0;
  logic [10:0]   held;

  always #5 clk = ~clk;

  conv_egress #(.DEPTH(8), .LAT(2), .DIM_W(16)) dut (
    .clk          (clk),
    .arst         (arst),
    .in_vld_i     (in_vld),
    .in_dat_i     (in_dat),
    .in_pos_i     (in_pos),
    .in_rdy_o     (in_rdy),
    .m_tvalid_o   (m_tvalid),
    .m_tdata_o    (m_tdata),
    .m_tuser_o    (m_tuser),
    .m_tlast_o    (m_tlast),
    .m_tready_i   (m_tready),
    .cfg_width_i  (cfg_w),
    .cfg_height_i (cfg_h),
    .frame_done_o (frame_done),
    .err_o        (err),
    .err_clr_i    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (arst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        check("hold", {m_tvalid, m_tdata, m_tuser, m_tlast}, held);
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          check("spurious_beat", 1, 0);
        end else begin
          egress_entry_t e;
          e = q.pop_front();
          check("beat", {m_tdata, m_tuser, m_tlast},
                {e.pix, e.sof, e.eol});
        end
      end
      stall_q = m_tvalid && !m_tready;
      held    = {m_tvalid, m_tdata, m_tuser, m_tlast};
    end
  end

  function automatic kernel_pos_t mkpos(int c, int r, int w, int h);
    kernel_pos_t p;
    p    = '0;
    p.n2 = (r == 0);
    p.n1 = (r == 0);
    p.w2 = (c == 0);
    p.e2 = (c == w - 1);
    p.s2 = (r == h - 1);
    return p;
  endfunction

  task automatic set_in(input logic [7:0] pix, input kernel_pos_t p,
                        input bit push, input bit esof, input bit eeol);
    in_vld = 1'b1;
    in_dat = pix;
    in_pos = p;
    if (push) q.push_back('{pix: pix, sof: esof, eol: eeol});
  endtask

  task automatic set_frame(input int k, input int w, input int h,
                           input bit push);
    int c, r;
    c = k % w;
    r = (k / w) % h;
    set_in(8'(k + 8'h40), mkpos(c, r, w, h), push,
           (c == 0 && r == 0), (c == w - 1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic beat(input logic [7:0] pix, input kernel_pos_t p,
                      input bit esof, input bit eeol);
    set_in(pix, p, 1'b1, esof, eeol);
    step();
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    step();
    step();
    arst = 1'b0;
    q.delete();
    step();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check(tag, q.size(), 0);
  endtask

  initial begin
    kernel_pos_t p;
    int k, first_low, cyc;
    bit r1, r2, nr;

    arst = 1'b1; in_vld = 1'b0; in_dat = '0; in_pos = '0;
    m_tready = 1'b1; cfg_w = 16'd4; cfg_h = 16'd3; err_clr = 1'b0;
    #12;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", {m_tdata, m_tuser, m_tlast}, 0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_err", err, 0);
    check("rst_done", frame_done, 0);
    arst = 1'b0;
    step();

    // 4x3 frame, continuous
    for (int i = 0; i < 12; i++) begin
      set_frame(i, 4, 3, 1'b1);
      step();
      if (i == 10) check("done_early", frame_done, 0);
      if (i == 11) check("done_pulse", frame_done, 1);
    end
    step();
    check("done_one_cycle", frame_done, 0);
    drain("frame_drain");
    check("frame_err", err, 0);

    // back-pressure with LAT-cycle upstream
    do_reset();
    cfg_w = 16'd4; cfg_h = 16'd5; m_tready = 1'b0;
    r1 = 1'b1; r2 = 1'b1; k = 0; first_low = -1;
    for (cyc = 0; cyc < 14; cyc++) begin
      if (!in_rdy && first_low < 0) first_low = cyc;
      nr = in_rdy;
      if (r2) begin
        set_frame(k, 4, 5, 1'b1);
        k++;
      end
      r2 = r1; r1 = nr;
      step();
    end
    check("bp_first_low", first_low, 6);
    check("bp_accepted", k, 8);
    check("bp_in_rdy", in_rdy, 0);
    check("bp_no_ovf", err, 0);
    m_tready = 1'b1;
    set_frame(k, 4, 5, 1'b1);
    k++;
    nr = in_rdy; r2 = r1; r1 = nr;
    step();
    check("full_pushpop", err, 0);
    cyc = 0;
    while (k < 20 && cyc < 200) begin
      nr = in_rdy;
      if (r2) begin
        set_frame(k, 4, 5, 1'b1);
        k++;
      end
      r2 = r1; r1 = nr;
      step();
      cyc++;
    end
    check("bp_all_offered", k, 20);
    drain("bp_drain");
    check("bp_err", err, 0);

    // overflow ignoring credit
    do_reset();
    cfg_w = 16'd4; cfg_h = 16'd3; m_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_frame(i, 4, 3, i < 8);
      step();
    end
    check("ovf_err", err, 3'b001);
    clr_pulse();
    check("ovf_clr", err, 3'b000);
    m_tready = 1'b1;
    drain("ovf_drain");

    // geometry errors and resync
    do_reset();
    cfg_w = 16'd4; cfg_h = 16'd3; m_tready = 1'b1;
    p = '0; p.n2 = 1; p.w2 = 1;
    beat(8'h10, p, 1, 0);
    beat(8'h11, kernel_pos_t'(0), 0, 0);
    p = '0; p.e2 = 1;
    beat(8'h12, p, 0, 1);
    check("geo_eol_err", err, 3'b100);
    clr_pulse();
    check("geo_clr", err, 3'b000);
    beat(8'h13, p, 0, 1);
    p = '0; p.w2 = 1;
    beat(8'h14, p, 0, 0);
    beat(8'h15, kernel_pos_t'(0), 0, 0);
    p = '0; p.n2 = 1; p.w2 = 1;
    beat(8'h16, p, 1, 0);
    check("geo_sof_err", err, 3'b010);
    clr_pulse();
    beat(8'h17, kernel_pos_t'(0), 0, 0);
    beat(8'h18, kernel_pos_t'(0), 0, 0);
    p = '0; p.e2 = 1;
    beat(8'h19, p, 0, 1);
    check("geo_resync", err, 3'b000);
    beat(8'h1a, kernel_pos_t'(0), 0, 0);
    p = '0; p.n2 = 1; p.w2 = 1;
    err_clr = 1'b1;
    beat(8'h1b, p, 1, 0);
    err_clr = 1'b0;
    check("clr_vs_event", err, 3'b010);
    clr_pulse();
    check("geo_final_clr", err, 3'b000);
    drain("geo_drain");

    // asynchronous reset mid-frame
    do_reset();
    cfg_w = 16'd4; cfg_h = 16'd3; m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_frame(i, 4, 3, 1'b1);
      step();
    end
    check("pre_rst_valid", m_tvalid, 1);
    #2;
    arst = 1'b1;
    #1;
    check("arst_tvalid", m_tvalid, 0);
    check("arst_tdata", {m_tdata, m_tuser, m_tlast}, 0);
    check("arst_in_rdy", in_rdy, 1);
    q.delete();
    @(posedge clk);
    #3;
    arst = 1'b0;
    cfg_w = 16'd2; cfg_h = 16'd2; m_tready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      set_frame(i, 2, 2, 1'b1);
      step();
      if (i == 3) check("rst_frame_done", frame_done, 1);
    end
    drain("rst_drain");
    check("rst_frame_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
